alu_uart_requester: RTL and testbench

Host-side initiator for the UART ALU link. It takes a local request consisting of operand A, operand B and an opcode, and serialises it as three bytes into the UART core transmit FIFO. It then waits for the single result byte on the UART core receive FIFO and returns it with a done pulse, or reports a timeout. It sits next to a `uart_core` instance and drives it from the opposite end of the link to the ALU-side `interface` block.

---
 rtl/alu_uart_requester.sv | 147 ++++++++++++++
 tb/tb_alu_uart_requester.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_requester.sv
// Host-side requester for the UART ALU link: sends A, B and opcode bytes, then waits for one result byte.
// Optional build macro ALU_REQ_FLUSH_EN adds a FLUSH state that drops stale RX bytes before sending.
module alu_uart_requester #(
   parameter int BUS_SIZE       = 8,
   parameter int OPCODE_W       = 6,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int TO_BITS        = 20
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [BUS_SIZE-1:0] i_op_a,
   input  logic [BUS_SIZE-1:0] i_op_b,
   input  logic [OPCODE_W-1:0] i_op_code,
   output logic                busy,
   output logic                done,
   output logic                timeout,
   output logic [BUS_SIZE-1:0] o_result,
   output logic                wr_uart,
   output logic [BUS_SIZE-1:0] w_data,
   input  logic                tx_full,
   output logic                rd_uart,
   input  logic [BUS_SIZE-1:0] r_data,
   input  logic                rx_empty
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
`ifdef ALU_REQ_FLUSH_EN
      ST_FLUSH    = 3'd1,
`endif
      ST_SEND_A   = 3'd2,
      ST_SEND_B   = 3'd3,
      ST_SEND_OP  = 3'd4,
      ST_WAIT_RES = 3'd5,
      ST_FINISH   = 3'd6
   } state_t;

   localparam logic [TO_BITS-1:0] CNT_LAST = TO_BITS'(TIMEOUT_CYCLES - 1);

   state_t              state_r;
   logic [BUS_SIZE-1:0] a_r;
   logic [BUS_SIZE-1:0] b_r;
   logic [OPCODE_W-1:0] op_r;
   logic [TO_BITS-1:0]  cnt_r;

   // FIFO strobes and TX byte decoded from state and FIFO flags
   always_comb begin
      wr_uart = 1'b0;
      rd_uart = 1'b0;
      w_data  = '0;
      case (state_r)
`ifdef ALU_REQ_FLUSH_EN
         ST_FLUSH:    rd_uart = !rx_empty;
`endif
         ST_SEND_A: begin
            wr_uart = !tx_full;
            w_data  = a_r;
         end
         ST_SEND_B: begin
            wr_uart = !tx_full;
            w_data  = b_r;
         end
         ST_SEND_OP: begin
            wr_uart = !tx_full;
            w_data  = BUS_SIZE'(op_r);
         end
         ST_WAIT_RES: rd_uart = !rx_empty;
         default: begin
            wr_uart = 1'b0;
            rd_uart = 1'b0;
            w_data  = '0;
         end
      endcase
   end

   // Request sequencer with registered status outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= ST_IDLE;
         a_r      <= '0;
         b_r      <= '0;
         op_r     <= '0;
         cnt_r    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         timeout  <= 1'b0;
         o_result <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_r     <= i_op_a;
                  b_r     <= i_op_b;
                  op_r    <= i_op_code;
                  busy    <= 1'b1;
                  timeout <= 1'b0;
`ifdef ALU_REQ_FLUSH_EN
                  state_r <= ST_FLUSH;
`else
                  state_r <= ST_SEND_A;
`endif
               end
            end
`ifdef ALU_REQ_FLUSH_EN
            ST_FLUSH: if (rx_empty) state_r <= ST_SEND_A;
`endif
            ST_SEND_A: if (wr_uart) state_r <= ST_SEND_B;
            ST_SEND_B: if (wr_uart) state_r <= ST_SEND_OP;
            ST_SEND_OP: begin
               if (wr_uart) begin
                  cnt_r   <= '0;
                  state_r <= ST_WAIT_RES;
               end
            end
            // A byte on the terminal count cycle still counts as a result
            ST_WAIT_RES: begin
               if (rd_uart) begin
                  o_result <= r_data;
                  timeout  <= 1'b0;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state_r  <= ST_FINISH;
               end else if (cnt_r == CNT_LAST) begin
                  timeout  <= 1'b1;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state_r  <= ST_FINISH;
               end else begin
                  cnt_r    <= cnt_r + TO_BITS'(1);
               end
            end
            ST_FINISH: begin
               done    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_uart_requester.sv
// Directed bench for alu_uart_requester with behavioural TX/RX FIFO models; short timeout (16 cycles).
module tb_alu_uart_requester;

   localparam int T = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] i_op_a, i_op_b;
   logic [5:0] i_op_code;
   logic       busy, done, timeout;
   logic [7:0] o_result;
   logic       wr_uart, rd_uart;
   logic [7:0] w_data;
   logic       tx_full;
   logic [7:0] r_data;
   logic       rx_empty;

   alu_uart_requester #(.BUS_SIZE(8), .OPCODE_W(6), .TIMEOUT_CYCLES(T), .TO_BITS(5)) dut (
      .clk(clk), .reset(reset), .start(start), .i_op_a(i_op_a), .i_op_b(i_op_b),
      .i_op_code(i_op_code), .busy(busy), .done(done), .timeout(timeout), .o_result(o_result),
      .wr_uart(wr_uart), .w_data(w_data), .tx_full(tx_full), .rd_uart(rd_uart),
      .r_data(r_data), .rx_empty(rx_empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [5:0] op;
      int         stall;
      bit         has_res;
      int         d;
      logic [7:0] res;
   } vec_t;

   logic [7:0] rxq[$];
   logic [7:0] txlog[$];
   int         wcyc[$];
   int         cyc_n = 0;
   int         rd_cnt = 0;
   int         rd_pre = 0;
   int         total = 0;
   int         bad = 0;
   bit         tx_full_v = 1'b0;
`ifdef ALU_REQ_FLUSH_EN
   localparam int FL = 1;
`else
   localparam int FL = 0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // One clock cycle: present FIFO flags, observe strobes, apply FIFO effects at the edge
   task automatic cyc();
      logic       wr_s, rd_s;
      logic [7:0] wd_s;
      tx_full  = tx_full_v;
      rx_empty = (rxq.size() == 0);
      r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
      #1;
      wr_s = wr_uart;
      rd_s = rd_uart;
      wd_s = w_data;
      if (wr_s && rd_s) chk("wr_rd_excl", {wr_s, rd_s}, 2'b00);
      if (tx_full && wr_s) chk("wr_when_full", wr_s, 1'b0);
      @(posedge clk);
      if (wr_s) begin
         txlog.push_back(wd_s);
         wcyc.push_back(cyc_n);
      end
      if (rd_s && rxq.size() != 0) begin
         void'(rxq.pop_front());
         rd_cnt++;
         if (txlog.size() == 0) rd_pre++;
      end
      @(negedge clk);
      cyc_n++;
   endtask

   task automatic run_vec(input vec_t v, input logic [7:0] prev_res, output logic [7:0] new_res);
      int  t0, stall, w;
      bit  pushed, got, exp_to;
      logic [7:0] exp_res;
      txlog.delete(); wcyc.delete(); rd_cnt = 0;
      i_op_a = v.a; i_op_b = v.b; i_op_code = v.op; start = 1'b1;
      cyc();
      start = 1'b0;
      i_op_a = ~v.a; i_op_b = ~v.b; i_op_code = ~v.op;
      t0 = cyc_n;
      chk("busy_after_accept", busy, 1'b1);
      chk("timeout_cleared", timeout, 1'b0);
      stall = v.stall; w = -1; pushed = 0; got = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         tx_full_v = (txlog.size() == 1 && stall > 0);
         if (tx_full_v) stall--;
         if (txlog.size() == 3) w++;
         if (v.has_res && !pushed && w == v.d) begin
            rxq.push_back(v.res);
            pushed = 1;
         end
         cyc();
         if (done) got = 1;
      end
      tx_full_v = 1'b0;
      exp_to  = !(v.has_res && v.d < T);
      exp_res = exp_to ? prev_res : v.res;
      chk("done_seen", got, 1'b1);
      chk("done_latency", w, exp_to ? T - 1 : v.d);
      chk("wr_count", txlog.size(), 3);
      chk("wr_a", txlog.size() > 0 ? txlog[0] : 8'hxx, v.a);
      chk("wr_b", txlog.size() > 1 ? txlog[1] : 8'hxx, v.b);
      chk("wr_op", txlog.size() > 2 ? txlog[2] : 8'hxx, {2'b00, v.op});
      chk("wr_first_cyc", wcyc.size() > 0 ? wcyc[0] - t0 : -1, FL);
      chk("wr_ab_gap", wcyc.size() > 1 ? wcyc[1] - wcyc[0] : -1, 1 + v.stall);
      chk("wr_bop_gap", wcyc.size() > 2 ? wcyc[2] - wcyc[1] : -1, 1);
      chk("timeout", timeout, exp_to);
      chk("o_result", o_result, exp_res);
      chk("rd_count", rd_cnt, exp_to ? 0 : 1);
      chk("busy_at_done", busy, 1'b0);
      cyc();
      chk("done_one_cycle", done, 1'b0);
      chk("timeout_held", timeout, exp_to);
      new_res = exp_res;
   endtask

   initial begin
      vec_t       vecs[5];
      logic [7:0] res_m;
      bit         got;
      vecs[0] = '{a: 8'h12, b: 8'h34, op: 6'h20, stall: 0, has_res: 1'b1, d: 10, res: 8'h46};
      vecs[1] = '{a: 8'hA5, b: 8'h5A, op: 6'h3F, stall: 5, has_res: 1'b1, d: 0,  res: 8'hC3};
      vecs[2] = '{a: 8'h01, b: 8'h02, op: 6'h03, stall: 0, has_res: 1'b0, d: 0,  res: 8'h00};
      vecs[3] = '{a: 8'hFF, b: 8'h00, op: 6'h01, stall: 0, has_res: 1'b1, d: T - 1, res: 8'h77};
      vecs[4] = '{a: 8'h80, b: 8'h7F, op: 6'h2A, stall: 2, has_res: 1'b1, d: 3,  res: 8'h5E};

      reset = 1'b0; start = 1'b0; i_op_a = 8'h00; i_op_b = 8'h00; i_op_code = 6'h00;
      tx_full = 1'b0; rx_empty = 1'b1; r_data = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      cyc();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_timeout", timeout, 1'b0);
      chk("rst_result", o_result, 8'h00);
      chk("rst_strobes", {wr_uart, rd_uart, w_data}, 10'h000);

      res_m = 8'h00;
      for (int i = 0; i < 5; i++) run_vec(vecs[i], res_m, res_m);

      // Extra start while busy is ignored; reset in WAIT_RES aborts without done
      txlog.delete();
      i_op_a = 8'h3C; i_op_b = 8'hC3; i_op_code = 6'h15; start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      start = 1'b1; i_op_a = 8'hEE;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      cyc();
      chk("busy_start_wr_count", txlog.size(), 3);
      chk("busy_start_wr_a", txlog.size() > 0 ? txlog[0] : 8'hxx, 8'h3C);
      chk("busy_start_wr_op", txlog.size() > 2 ? txlog[2] : 8'hxx, 8'h15);
      chk("wait_busy", busy, 1'b1);
      reset = 1'b0;
      #1;
      chk("abort_outputs", {busy, done, timeout, wr_uart, rd_uart}, 5'b00000);
      chk("abort_result", o_result, 8'h00);
      chk("abort_wdata", w_data, 8'h00);
      got = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         if (done) got = 1;
      end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         if (done || busy) got = 1;
      end
      chk("abort_no_done", got, 1'b0);
      chk("abort_no_requeue", txlog.size(), 3);

      // Stale RX bytes present before start
      rxq.push_back(8'hAA); rxq.push_back(8'hBB);
      txlog.delete(); rd_pre = 0; got = 0;
      i_op_a = 8'h11; i_op_b = 8'h22; i_op_code = 6'h33; start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
`ifdef ALU_REQ_FLUSH_EN
         if (txlog.size() == 3 && rxq.size() == 0) rxq.push_back(8'h99);
`endif
         cyc();
         if (done) got = 1;
      end
      chk("stale_done", got, 1'b1);
      chk("stale_wr_count", txlog.size(), 3);
`ifdef ALU_REQ_FLUSH_EN
      chk("stale_pops_before_wr", rd_pre, 2);
      chk("stale_result", o_result, 8'h99);
      chk("stale_rx_left", rxq.size(), 0);
`else
      chk("stale_pops_before_wr", rd_pre, 0);
      chk("stale_result", o_result, 8'hAA);
      chk("stale_rx_left", rxq.size(), 1);
`endif
      rxq.delete();
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
